// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: APB3 master for the UART APB slave register map.
// After reset (or cfg_start) it writes baud (0x4), thresholds (0xC) and enable
// (0x8), then arbitrates RX-drain reads and TX push writes of 0x0.
// Ports:
//   pclk, presetn          clock, async active-low reset
//   cfg_start / cfg_done   re-run configuration / configured flag
//   tx_valid, tx_data,
//   tx_ready, tx_block     TX byte handshake (tx_ready strobes on completion)
//   irq_rx                 level request for an RX read of 0x0
//   rx_valid, rx_data      one-cycle strobe with the received byte
//   err_flag               sticky slave-error (or timeout) flag
//   psel..pslverr          APB3 master interface
// Optional feature: define UART_SEQ_TIMEOUT_EN to abort transfers whose pready
// stays low for TO_CYC cycles in ACCESS.
module uart_apb_sequencer #(
  parameter logic [10:0] BAUD_INIT = 11'd977,
  parameter logic [3:0]  THR_INIT  = 4'h0,
  parameter logic [7:0]  EN_INIT   = 8'h22,
  parameter int unsigned GAP_CYC   = 2,
  parameter int unsigned TO_CYC    = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        cfg_start,
  output logic        cfg_done,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  input  logic        tx_block,
  input  logic        irq_rx,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        err_flag,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  output logic [2:0]  pprot,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr
);

  localparam int unsigned GAP_W = 3;
  localparam int unsigned TO_W  = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  if (GAP_CYC < 1 || GAP_CYC > 7 || TO_CYC < 1) begin : g_param_chk
    $error("uart_apb_sequencer: GAP_CYC must be 1..7 and TO_CYC at least 1");
  end

  typedef enum logic [2:0] {CFG, IDLE, SETUP, ACCESS, GAP} state_t;

  state_t             state_q, state_d;
  logic [1:0]         cfg_idx_q, cfg_idx_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               cfg_pend_q, cfg_pend_d;
  logic               is_cfg_q, is_cfg_d;
  logic               is_tx_q, is_tx_d;
  logic               psel_d, penable_d, pwrite_d;
  logic [31:0]        paddr_d, pwdata_d;
  logic               cfg_done_d, err_d, rx_valid_d, tx_ready_d;
  logic [7:0]         rx_data_d;
  logic               launch, load_cfg;
`ifdef UART_SEQ_TIMEOUT_EN
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
`endif

  // Only the low byte of read data is meaningful to this master.
  logic unused_prdata_hi;
  assign unused_prdata_hi = ^prdata[31:8];

  assign pstrb = 4'hF;
  assign pprot = 3'b000;

  function automatic logic [31:0] cfg_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_addr = 32'h4;
      2'd1:    cfg_addr = 32'hC;
      default: cfg_addr = 32'h8;
    endcase
  endfunction

  function automatic logic [31:0] cfg_data(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_data = 32'(BAUD_INIT);
      2'd1:    cfg_data = 32'(THR_INIT);
      default: cfg_data = 32'(EN_INIT);
    endcase
  endfunction

  // State and output registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= CFG;
      cfg_idx_q  <= 2'd0;
      gap_cnt_q  <= '0;
      cfg_pend_q <= 1'b0;
      is_cfg_q   <= 1'b0;
      is_tx_q    <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= 32'h0;
      pwdata     <= 32'h0;
      cfg_done   <= 1'b0;
      err_flag   <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h0;
      tx_ready   <= 1'b0;
`ifdef UART_SEQ_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cfg_idx_q  <= cfg_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      cfg_pend_q <= cfg_pend_d;
      is_cfg_q   <= is_cfg_d;
      is_tx_q    <= is_tx_d;
      psel       <= psel_d;
      penable    <= penable_d;
      pwrite     <= pwrite_d;
      paddr      <= paddr_d;
      pwdata     <= pwdata_d;
      cfg_done   <= cfg_done_d;
      err_flag   <= err_d;
      rx_valid   <= rx_valid_d;
      rx_data    <= rx_data_d;
      tx_ready   <= tx_ready_d;
`ifdef UART_SEQ_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  // Next-state, transfer selection and output next values.
  always_comb begin
    state_d    = state_q;
    cfg_idx_d  = cfg_idx_q;
    gap_cnt_d  = gap_cnt_q;
    cfg_pend_d = cfg_pend_q | cfg_start;
    is_cfg_d   = is_cfg_q;
    is_tx_d    = is_tx_q;
    pwrite_d   = pwrite;
    paddr_d    = paddr;
    pwdata_d   = pwdata;
    cfg_done_d = cfg_done;
    err_d      = err_flag;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data;
    tx_ready_d = 1'b0;
    launch     = 1'b0;
    load_cfg   = 1'b0;
`ifdef UART_SEQ_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif

    unique case (state_q)
      CFG, IDLE: launch = 1'b1;
      SETUP: begin
        state_d = ACCESS;
`ifdef UART_SEQ_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          if (pslverr) err_d = 1'b1;
          if (pwrite) begin
            tx_ready_d = is_tx_q;
          end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = prdata[7:0];
          end
          state_d   = GAP;
          gap_cnt_d = GAP_W'(GAP_CYC - 1);
        end
`ifdef UART_SEQ_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
          // Abandon the stuck transfer: no strobe, flag the error.
          err_d     = 1'b1;
          state_d   = GAP;
          gap_cnt_d = GAP_W'(GAP_CYC - 1);
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      GAP: begin
        if (gap_cnt_q == '0) launch = 1'b1;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = CFG;
    endcase

    // Pick the next transfer; from GAP this goes straight to SETUP so that
    // back-to-back transfers start 2+GAP_CYC cycles apart.
    if (launch) begin
      state_d  = IDLE;
      is_cfg_d = 1'b0;
      is_tx_d  = 1'b0;
      if (cfg_pend_q || cfg_start) begin
        cfg_pend_d = 1'b0;
        cfg_done_d = 1'b0;
        err_d      = 1'b0;
        cfg_idx_d  = 2'd0;
        load_cfg   = 1'b1;
      end else if (state_q == CFG) begin
        load_cfg = 1'b1;
      end else if (state_q == GAP && is_cfg_q) begin
        if (cfg_idx_q != 2'd2) begin
          cfg_idx_d = cfg_idx_q + 1'b1;
          load_cfg  = 1'b1;
        end else begin
          cfg_done_d = 1'b1;
        end
      end else if (cfg_done) begin
        if (irq_rx) begin
          state_d  = SETUP;
          paddr_d  = 32'h0;
          pwdata_d = 32'h0;
          pwrite_d = 1'b0;
        end else if (tx_valid && !tx_block) begin
          state_d  = SETUP;
          paddr_d  = 32'h0;
          pwdata_d = 32'(tx_data);
          pwrite_d = 1'b1;
          is_tx_d  = 1'b1;
        end
      end
      if (load_cfg) begin
        state_d  = SETUP;
        paddr_d  = cfg_addr(cfg_idx_d);
        pwdata_d = cfg_data(cfg_idx_d);
        pwrite_d = 1'b1;
        is_cfg_d = 1'b1;
      end
    end

    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
  end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// tb_uart_apb_sequencer: self-checking bench for uart_apb_sequencer.
// Expected APB transfers are queued when requests are driven and popped when
// the DUT completes a transfer; a vector table covers RX/TX traffic and
// hand-written sequences cover reset, re-configuration and stalls.
module tb_uart_apb_sequencer;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cfg_start, cfg_done;
  logic        tx_valid, tx_ready, tx_block;
  logic [7:0]  tx_data;
  logic        irq_rx, rx_valid;
  logic [7:0]  rx_data;
  logic        err_flag;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;
  logic [31:0] prdata;

  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rx;
    logic [7:0]  rxd;
    logic        tx;
  } exp_t;

  typedef struct {
    logic        rd;
    logic [7:0]  txd;
    logic [31:0] rdat;
    logic        serr;
    logic [31:0] e_wdata;
    logic [7:0]  e_rxd;
    logic        e_err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  uart_apb_sequencer dut (
    .pclk(pclk), .presetn(presetn), .cfg_start(cfg_start), .cfg_done(cfg_done),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_block(tx_block),
    .irq_rx(irq_rx), .rx_valid(rx_valid), .rx_data(rx_data), .err_flag(err_flag),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for a completing APB access, check it against the queue
  // head, then check the completion strobes one cycle later.
  task automatic wait_done(input string name, output int unsigned t);
    int   k;
    exp_t e;
    k = 0;
    while (!(psel && penable && pready) && k < 200) begin
      @(negedge pclk);
      k++;
    end
    t = cyc;
    if (k >= 200) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: no completed transfer within 200 cycles", name);
      return;
    end
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: unexpected transfer to addr 0x%0h", name, paddr);
      @(negedge pclk);
      return;
    end
    e = sb.pop_front();
    chk({name, " pwrite"}, 32'(pwrite), 32'(e.wr));
    chk({name, " paddr"}, paddr, e.addr);
    if (e.wr) chk({name, " pwdata"}, pwdata, e.data);
    chk({name, " pstrb"}, 32'(pstrb), 32'hF);
    chk({name, " pprot"}, 32'(pprot), 32'h0);
    @(negedge pclk);
    chk({name, " rx_valid"}, 32'(rx_valid), 32'(e.rx));
    chk({name, " tx_ready"}, 32'(tx_ready), 32'(e.tx));
    if (e.rx) chk({name, " rx_data"}, 32'(rx_data), 32'(e.rxd));
  endtask

  // Three configuration writes, 4 cycles apart, then cfg_done.
  task automatic run_cfg(input string tag);
    int unsigned t0, t1, t2;
    sb.push_back('{1'b1, 32'h4, 32'd977, 1'b0, 8'h0, 1'b0});
    sb.push_back('{1'b1, 32'hC, 32'h0,   1'b0, 8'h0, 1'b0});
    sb.push_back('{1'b1, 32'h8, 32'h22,  1'b0, 8'h0, 1'b0});
    wait_done({tag, " cfg0"}, t0);
    chk({tag, " cfg_done during cfg"}, 32'(cfg_done), 32'h0);
    chk({tag, " err_flag after cfg0"}, 32'(err_flag), 32'h0);
    wait_done({tag, " cfg1"}, t1);
    wait_done({tag, " cfg2"}, t2);
    chk({tag, " cfg spacing 0-1"}, t1 - t0, 32'd4);
    chk({tag, " cfg spacing 1-2"}, t2 - t1, 32'd4);
    chk({tag, " cfg_done before gap end"}, 32'(cfg_done), 32'h0);
    repeat (2) @(negedge pclk);
    chk({tag, " cfg_done set"}, 32'(cfg_done), 32'h1);
  endtask

  initial begin
    int unsigned t;
    int          k;
    logic        seen;

    vecs[0] = '{1'b0, 8'h5A, 32'h0,        1'b0, 32'h5A, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 8'h00, 32'h0000_00A7, 1'b0, 32'h0,  8'hA7, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 32'h0,        1'b0, 32'h00, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 8'h00, 32'h1234_5681, 1'b0, 32'h0,  8'h81, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 32'h0,        1'b0, 32'hFF, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 8'h00, 32'h0000_0055, 1'b1, 32'h0,  8'h55, 1'b1};
    vecs[6] = '{1'b0, 8'h11, 32'h0,        1'b0, 32'h11, 8'h00, 1'b1};
    vecs[7] = '{1'b1, 8'h00, 32'hFFFF_FFC3, 1'b0, 32'h0,  8'hC3, 1'b1};

    presetn = 1'b0; cfg_start = 1'b0; tx_valid = 1'b0; tx_data = 8'h0;
    tx_block = 1'b0; irq_rx = 1'b0; pready = 1'b1; prdata = 32'h0; pslverr = 1'b0;

    // Reset values.
    repeat (3) @(negedge pclk);
    chk("rst psel", 32'(psel), 0);
    chk("rst penable", 32'(penable), 0);
    chk("rst pwrite", 32'(pwrite), 0);
    chk("rst paddr", paddr, 0);
    chk("rst pwdata", pwdata, 0);
    chk("rst cfg_done", 32'(cfg_done), 0);
    chk("rst tx_ready", 32'(tx_ready), 0);
    chk("rst rx_valid", 32'(rx_valid), 0);
    chk("rst rx_data", 32'(rx_data), 0);
    chk("rst err_flag", 32'(err_flag), 0);
    presetn = 1'b1;
    run_cfg("boot");

    // RX read has priority over a simultaneous TX write.
    irq_rx = 1'b1; tx_valid = 1'b1; tx_data = 8'h3C; prdata = 32'hA7;
    sb.push_back('{1'b0, 32'h0, 32'h0, 1'b1, 8'hA7, 1'b0});
    sb.push_back('{1'b1, 32'h0, 32'h3C, 1'b0, 8'h0, 1'b1});
    wait_done("prio rd", t);
    irq_rx = 1'b0;
    wait_done("prio wr", t);
    tx_valid = 1'b0;

    // tx_block holds off TX writes.
    tx_block = 1'b1; tx_valid = 1'b1; tx_data = 8'h6E; seen = 1'b0;
    repeat (10) begin
      @(negedge pclk);
      if (psel) seen = 1'b1;
    end
    chk("tx_block no psel", 32'(seen), 0);
    tx_block = 1'b0;
    sb.push_back('{1'b1, 32'h0, 32'h6E, 1'b0, 8'h0, 1'b1});
    wait_done("tx after unblock", t);
    tx_valid = 1'b0;

    // Table-driven RX/TX traffic.
    for (int i = 0; i < 8; i++) begin
      prdata = vecs[i].rdat;
      pslverr = vecs[i].serr;
      if (vecs[i].rd) irq_rx = 1'b1;
      else begin
        tx_valid = 1'b1;
        tx_data = vecs[i].txd;
      end
      sb.push_back('{!vecs[i].rd, 32'h0, vecs[i].e_wdata, vecs[i].rd, vecs[i].e_rxd, !vecs[i].rd});
      wait_done($sformatf("vec%0d", i), t);
      irq_rx = 1'b0; tx_valid = 1'b0; pslverr = 1'b0;
      chk($sformatf("vec%0d err_flag", i), 32'(err_flag), 32'(vecs[i].e_err));
      @(negedge pclk);
      chk($sformatf("vec%0d strobes cleared", i), 32'({rx_valid, tx_ready}), 0);
    end

    // cfg_start from IDLE clears err_flag and reruns configuration.
    cfg_start = 1'b1;
    @(negedge pclk);
    cfg_start = 1'b0;
    run_cfg("recfg");

    // cfg_start during a stalled TX write: write completes first.
    pready = 1'b0; tx_valid = 1'b1; tx_data = 8'h96;
    sb.push_back('{1'b1, 32'h0, 32'h96, 1'b0, 8'h0, 1'b1});
    k = 0;
    while (!(psel && penable) && k < 200) begin @(negedge pclk); k++; end
    if (k >= 200) begin
      n_vec++; n_bad++;
      $display("FAIL stall wr: ACCESS not reached");
    end
    cfg_start = 1'b1;
    @(negedge pclk);
    cfg_start = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    pready = 1'b1;
    wait_done("stall wr", t);
    tx_valid = 1'b0;
    run_cfg("midcfg");

    // pready stuck low in ACCESS.
    pready = 1'b0; irq_rx = 1'b1; prdata = 32'h42;
    k = 0;
    while (!(psel && penable) && k < 200) begin @(negedge pclk); k++; end
`ifdef UART_SEQ_TIMEOUT_EN
    k = 0;
    while (psel && penable && k < 100) begin @(negedge pclk); k++; end
    irq_rx = 1'b0;
    chk("timeout access cycles", 32'(k), 32'd16);
    chk("timeout err_flag", 32'(err_flag), 1);
    chk("timeout no strobe", 32'({rx_valid, tx_ready}), 0);
    pready = 1'b1;
    repeat (4) @(negedge pclk);
`else
    repeat (30) @(negedge pclk);
    chk("stuck psel held", 32'(psel), 1);
    chk("stuck penable held", 32'(penable), 1);
    chk("stuck no rx_valid", 32'(rx_valid), 0);
    pready = 1'b1;
    sb.push_back('{1'b0, 32'h0, 32'h0, 1'b1, 8'h42, 1'b0});
    wait_done("stuck rd", t);
    irq_rx = 1'b0;
`endif

    // Async reset mid-transfer drops the bus immediately.
    pready = 1'b0; tx_valid = 1'b1; tx_data = 8'hE1;
    k = 0;
    while (!(psel && penable) && k < 200) begin @(negedge pclk); k++; end
    #1 presetn = 1'b0;
    #1;
    chk("async rst psel", 32'(psel), 0);
    chk("async rst penable", 32'(penable), 0);
    chk("async rst paddr+pwdata", paddr | pwdata, 0);
    chk("async rst cfg_done", 32'(cfg_done), 0);
    tx_valid = 1'b0; pready = 1'b1;
    @(negedge pclk);
    presetn = 1'b1;
    run_cfg("rst2");

    chk("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
